// File: rtl/choice_sampler.sv
// Once-per-frame column choice register: a delayed edge on ROW==LATCH_ROW commits
// the player's choice, with optional sticky capture and post-change hold-off.
module choice_sampler #(
  parameter int WIDTH       = 4,
  parameter int ROW_W       = 4,
  parameter int LATCH_ROW   = 0,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int HOLD_FRAMES = 0,
  parameter int RESET_VAL   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] choice_in,
  input  logic [ROW_W-1:0] ROW,
  output logic [WIDTH-1:0] choice,
  output logic             update,
  output logic             frame,
  output logic             locked
);

  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_FRAMES);
  localparam logic [ROW_W-1:0]  LATCH_VAL  = ROW_W'(LATCH_ROW);
  localparam logic [WIDTH-1:0]  RESET_CHOICE = WIDTH'(RESET_VAL);

  logic [SYNC_STAGES:0] sync_q, sync_d;
  logic [WIDTH-1:0]     choice_q, choice_d;
  logic [WIDTH-1:0]     pend_q, pend_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 update_q, update_d;
  logic                 frame_q, frame_d;
  logic                 locked_q, locked_d;
  logic                 hit;
  logic                 tick;
  logic [WIDTH-1:0]     cand;

  assign hit  = (ROW == LATCH_VAL);
  assign tick = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-1:0], hit};
    choice_d = choice_q;
    pend_d   = pend_q;
    hold_d   = hold_q;
    update_d = 1'b0;
    frame_d  = 1'b0;
    cand     = choice_in;

    // Sticky mode remembers the last non-zero choice of the current frame only.
    if (MODE == 1) begin
      if (choice_in == '0) begin
        cand = pend_q;
      end
      if (tick) begin
        pend_d = '0;
      end else if (choice_in != '0) begin
        pend_d = choice_in;
      end
    end else begin
      pend_d = '0;
    end

    if (tick) begin
      frame_d = 1'b1;
      if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else if (cand != choice_q) begin
        choice_d = cand;
        update_d = 1'b1;
        hold_d   = HOLD_INIT;
      end
    end

    locked_d = (hold_d != '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q   <= '0;
      choice_q <= RESET_CHOICE;
      pend_q   <= '0;
      hold_q   <= '0;
      update_q <= 1'b0;
      frame_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      choice_q <= choice_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      update_q <= update_d;
      frame_q  <= frame_d;
      locked_q <= locked_d;
    end
  end

  assign choice = choice_q;
  assign update = update_q;
  assign frame  = frame_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_choice_sampler.sv
// Directed bench for choice_sampler: four instances cover default sampling, sticky
// mode, hold-off and a deep sync chain with a non-zero reset value.
module tb_choice_sampler;

  logic       clk;
  logic       rst0, rst1, rst2, rst3;
  logic [3:0] row0, row1, row2;
  logic [2:0] row3;
  logic [3:0] cin0, cin1, cin2, cin3;
  logic [3:0] choice0, choice1, choice2, choice3;
  logic       update0, update1, update2, update3;
  logic       frame0, frame1, frame2, frame3;
  logic       locked0, locked1, locked2, locked3;

  int testsRun;
  int testsFailed;
  int pulses;

  choice_sampler u0 (
    .CLK(clk), .RST(rst0), .choice_in(cin0), .ROW(row0),
    .choice(choice0), .update(update0), .frame(frame0), .locked(locked0)
  );

  choice_sampler #(.MODE(1)) u1 (
    .CLK(clk), .RST(rst1), .choice_in(cin1), .ROW(row1),
    .choice(choice1), .update(update1), .frame(frame1), .locked(locked1)
  );

  choice_sampler #(.HOLD_FRAMES(2), .RESET_VAL(2)) u2 (
    .CLK(clk), .RST(rst2), .choice_in(cin2), .ROW(row2),
    .choice(choice2), .update(update2), .frame(frame2), .locked(locked2)
  );

  choice_sampler #(.SYNC_STAGES(4), .LATCH_ROW(5), .ROW_W(3), .RESET_VAL(4'hA)) u3 (
    .CLK(clk), .RST(rst3), .choice_in(cin3), .ROW(row3),
    .choice(choice3), .update(update3), .frame(frame3), .locked(locked3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq [5];
    logic [3:0] expChoice [4];
    logic       expUpdate [4];
    logic       expLocked [4];

    seq       = '{0, 3, 0, 7, 0};
    expChoice = '{4'h9, 4'h9, 4'h9, 4'h6};
    expUpdate = '{1'b1, 1'b0, 1'b0, 1'b1};
    expLocked = '{1'b1, 1'b1, 1'b0, 1'b1};
    testsRun    = 0;
    testsFailed = 0;

    {rst0, rst1, rst2, rst3} = 4'b1111;
    row0 = 4'd3; row1 = 4'd3; row2 = 4'd3; row3 = 3'd0;
    cin0 = 4'h5; cin1 = 4'h0; cin2 = 4'h9; cin3 = 4'h3;
    repeat (3) stepCycle();

    checkOutput("reset choice0", 32'(choice0), 32'h0);
    checkOutput("reset update0", 32'(update0), 32'h0);
    checkOutput("reset frame0",  32'(frame0),  32'h0);
    checkOutput("reset locked0", 32'(locked0), 32'h0);
    checkOutput("reset choice2", 32'(choice2), 32'h2);
    checkOutput("reset choice3", 32'(choice3), 32'hA);

    {rst0, rst1, rst2, rst3} = 4'b0000;
    repeat (3) stepCycle();
    checkOutput("idle frame0", 32'(frame0), 32'h0);

    // Default instance: commit lands two edges after the first sampled hit.
    row0 = 4'd0;
    stepCycle();
    checkOutput("u0 edge n frame", 32'(frame0), 32'h0);
    stepCycle();
    checkOutput("u0 edge n+1 choice", 32'(choice0), 32'h0);
    checkOutput("u0 edge n+1 update", 32'(update0), 32'h0);
    stepCycle();
    checkOutput("u0 commit choice", 32'(choice0), 32'h5);
    checkOutput("u0 commit update", 32'(update0), 32'h1);
    checkOutput("u0 commit frame",  32'(frame0),  32'h1);
    stepCycle();
    checkOutput("u0 update pulse width", 32'(update0), 32'h0);
    checkOutput("u0 frame pulse width",  32'(frame0),  32'h0);
    pulses = 0;
    repeat (50) begin
      stepCycle();
      pulses += int'(frame0) + int'(update0);
    end
    checkOutput("u0 held row pulses", 32'(pulses), 32'h0);

    row0 = 4'd3;
    repeat (2) stepCycle();
    row0 = 4'd0;
    repeat (3) stepCycle();
    checkOutput("u0 same frame",  32'(frame0),  32'h1);
    checkOutput("u0 same update", 32'(update0), 32'h0);
    checkOutput("u0 same choice", 32'(choice0), 32'h5);

    // Sticky instance.
    for (int i = 0; i < 5; i++) begin
      cin1 = 4'(seq[i]);
      stepCycle();
    end
    row1 = 4'd0;
    repeat (3) stepCycle();
    checkOutput("u1 sticky choice", 32'(choice1), 32'h7);
    checkOutput("u1 sticky update", 32'(update1), 32'h1);
    row1 = 4'd3;
    repeat (2) stepCycle();
    row1 = 4'd0;
    repeat (3) stepCycle();
    checkOutput("u1 zero frame choice", 32'(choice1), 32'h0);
    checkOutput("u1 zero frame update", 32'(update1), 32'h1);
    checkOutput("u1 zero frame frame",  32'(frame1),  32'h1);
    row1 = 4'd3;
    cin1 = 4'h3;
    repeat (2) stepCycle();
    row1 = 4'd0;
    repeat (2) stepCycle();
    cin1 = 4'h9;
    stepCycle();
    checkOutput("u1 tick edge wins", 32'(choice1), 32'h9);

    // Hold-off instance: four frames.
    for (int f = 0; f < 4; f++) begin
      row2 = 4'd3;
      repeat (2) stepCycle();
      if (f >= 1) cin2 = 4'h6;
      row2 = 4'd0;
      repeat (3) stepCycle();
      checkOutput($sformatf("u2 frame%0d choice", f), 32'(choice2), 32'(expChoice[f]));
      checkOutput($sformatf("u2 frame%0d update", f), 32'(update2), 32'(expUpdate[f]));
      checkOutput($sformatf("u2 frame%0d locked", f), 32'(locked2), 32'(expLocked[f]));
      checkOutput($sformatf("u2 frame%0d frame", f),  32'(frame2),  32'h1);
    end

    // Deep chain: commit at edge n+4.
    row3 = 3'd5;
    repeat (4) stepCycle();
    checkOutput("u3 edge n+3 frame",  32'(frame3),  32'h0);
    checkOutput("u3 edge n+3 choice", 32'(choice3), 32'hA);
    stepCycle();
    checkOutput("u3 edge n+4 frame",  32'(frame3),  32'h1);
    checkOutput("u3 edge n+4 choice", 32'(choice3), 32'h3);
    checkOutput("u3 edge n+4 update", 32'(update3), 32'h1);

    row3 = 3'd0;
    cin3 = 4'h4;
    repeat (8) stepCycle();
    row3 = 3'd5;
    stepCycle();
    row3 = 3'd0;
    pulses = 0;
    repeat (10) begin
      stepCycle();
      pulses += int'(frame3);
    end
    checkOutput("u3 glitch ticks",  32'(pulses),  32'h1);
    checkOutput("u3 glitch choice", 32'(choice3), 32'h4);

    // Reset while the hit is still inside the chain.
    row3 = 3'd5;
    stepCycle();
    #2 rst3 = 1'b1;
    #1;
    checkOutput("u3 async reset choice", 32'(choice3), 32'hA);
    row3 = 3'd0;
    repeat (2) stepCycle();
    rst3 = 1'b0;
    pulses = 0;
    repeat (10) begin
      stepCycle();
      pulses += int'(frame3) + int'(update3);
    end
    checkOutput("u3 post reset pulses", 32'(pulses),  32'h0);
    checkOutput("u3 post reset choice", 32'(choice3), 32'hA);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
